// File: rtl/pipelined_tree_accumulator.sv
// -----------------------------------------------------------------------------
// pipelined_tree_accumulator
//
// Reduces NO_IN signed elements through a fully registered adder tree and
// accumulates successive reduced vectors into one framed sum. A sum starts on
// a vector flagged in_first and is reported (one-cycle out_valid) on the vector
// flagged in_last. Accumulation either saturates or wraps at OUT_BITWIDTH; a
// sticky overflow flag records any out-of-range add within the sum.
//
// Pipeline: input register (tree level 0), D adder levels, accumulator.
// Latency from the sampling edge of in_last to out_valid is D+1 cycles,
// with D = ceil(log2(NO_IN)) (0 for NO_IN = 1).
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset, clears every register
//   in_valid   data_in / in_first / in_last are sampled this cycle
//   in_first   sampled vector starts a new sum
//   in_last    sampled vector ends the current sum
//   data_in    NO_IN packed signed elements, element i in slice [i]
//   out_valid  one-cycle pulse, data_out holds a completed sum
//   data_out   signed accumulator value, held between updates
//   overflow   some add of the sum shown on data_out left the output range
// -----------------------------------------------------------------------------
module pipelined_tree_accumulator #(
  parameter int IN_BITWIDTH  = 8,
  parameter int NO_IN        = 5,
  parameter int OUT_BITWIDTH = 12,
  parameter int SATURATE     = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic                                in_first,
  input  logic                                in_last,
  input  logic [NO_IN-1:0][IN_BITWIDTH-1:0]   data_in,
  output logic                                out_valid,
  output logic signed [OUT_BITWIDTH-1:0]      data_out,
  output logic                                overflow
);

  localparam int D  = (NO_IN > 1) ? $clog2(NO_IN) : 0;
  localparam int TW = IN_BITWIDTH + D;
  localparam int OW = OUT_BITWIDTH;

  if (NO_IN < 1) begin : g_no_in_check
    $error("pipelined_tree_accumulator: NO_IN must be at least 1");
  end
  if (OW < TW) begin : g_width_check
    $error("pipelined_tree_accumulator: OUT_BITWIDTH must be >= IN_BITWIDTH + ceil(log2(NO_IN))");
  end

  // True when the (OW+1)-bit sum does not fit in OW signed bits.
  function automatic logic sum_ovf(input logic signed [OW:0] s);
    return s[OW] != s[OW-1];
  endfunction

  // Reduce the (OW+1)-bit sum to OW bits: clamp when saturating, else wrap.
  function automatic logic signed [OW-1:0] clamp_or_wrap(input logic signed [OW:0] s);
    if ((SATURATE != 0) && sum_ovf(s)) begin
      if (s[OW]) return $signed({1'b1, {(OW-1){1'b0}}});
      else       return $signed({1'b0, {(OW-1){1'b1}}});
    end
    return $signed(s[OW-1:0]);
  endfunction

  // ---------------------------------------------------------------------------
  // Adder tree. Level l holds ceil(NO_IN / 2^l) nodes of IN_BITWIDTH+l bits.
  // Level 0 registers the inputs; each later level pairs adjacent nodes of the
  // previous level, and an odd leftover node is sign-extended and registered
  // so every path has the same number of stages.
  // ---------------------------------------------------------------------------
  for (genvar l = 0; l <= D; l++) begin : g_lvl
    localparam int N = (NO_IN + (1 << l) - 1) >> l;
    localparam int W = IN_BITWIDTH + l;

    logic signed [W-1:0] node_p [N];

    if (l == 0) begin : g_in
      for (genvar j = 0; j < N; j++) begin : g_node
        always_ff @(posedge clk or posedge rst) begin
          if (rst) node_p[j] <= '0;
          else     node_p[j] <= $signed(data_in[j]);
        end
      end
    end else begin : g_add
      localparam int NP = (NO_IN + (1 << (l - 1)) - 1) >> (l - 1);
      for (genvar j = 0; j < N; j++) begin : g_node
        if (2 * j + 1 < NP) begin : g_pair
          always_ff @(posedge clk or posedge rst) begin
            if (rst) node_p[j] <= '0;
            else     node_p[j] <= {g_lvl[l-1].node_p[2*j][W-2],   g_lvl[l-1].node_p[2*j]}
                                + {g_lvl[l-1].node_p[2*j+1][W-2], g_lvl[l-1].node_p[2*j+1]};
          end
        end else begin : g_pass
          always_ff @(posedge clk or posedge rst) begin
            if (rst) node_p[j] <= '0;
            else     node_p[j] <= {g_lvl[l-1].node_p[2*j][W-2], g_lvl[l-1].node_p[2*j]};
          end
        end
      end
    end
  end

  logic signed [TW-1:0] tree_sum;
  assign tree_sum = g_lvl[D].node_p[0];

  // ---------------------------------------------------------------------------
  // Control pipeline: flags travel alongside the tree, stage s matching level s.
  // ---------------------------------------------------------------------------
  logic vld_p   [D+1];
  logic first_p [D+1];
  logic last_p  [D+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= D; s++) begin
        vld_p[s]   <= 1'b0;
        first_p[s] <= 1'b0;
        last_p[s]  <= 1'b0;
      end
    end else begin
      vld_p[0]   <= in_valid;
      first_p[0] <= in_first;
      last_p[0]  <= in_last;
      for (int s = 1; s <= D; s++) begin
        vld_p[s]   <= vld_p[s-1];
        first_p[s] <= first_p[s-1];
        last_p[s]  <= last_p[s-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator stage. A first vector restarts from zero, which also discards
  // any unfinished sum. The add is one bit wider than the output so overflow
  // is visible before clamping or wrapping.
  // ---------------------------------------------------------------------------
  logic signed [OW-1:0] acc_p;
  logic                 ovf_p;
  logic                 out_vld_p;
  logic signed [OW:0]   sum_wide;

  always_comb begin
    sum_wide = '0;
    sum_wide = (first_p[D] ? {(OW+1){1'b0}} : {acc_p[OW-1], acc_p})
             + {{(OW+1-TW){tree_sum[TW-1]}}, tree_sum};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p     <= '0;
      ovf_p     <= 1'b0;
      out_vld_p <= 1'b0;
    end else begin
      out_vld_p <= vld_p[D] & last_p[D];
      if (vld_p[D]) begin
        acc_p <= clamp_or_wrap(sum_wide);
        ovf_p <= (ovf_p & ~first_p[D]) | sum_ovf(sum_wide);
      end
    end
  end

  assign out_valid = out_vld_p;
  assign data_out  = acc_p;
  assign overflow  = ovf_p;

endmodule
